// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder: format codes, the canonical nop,
// the request bundle and the signed range-check helper.
package imm_encoder_pkg;

  localparam logic [5:0] EXT_CTRL_ITYPE_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_CTRL_ITYPE       = 6'b010000;
  localparam logic [5:0] EXT_CTRL_STYPE       = 6'b001000;
  localparam logic [5:0] EXT_CTRL_BTYPE       = 6'b000100;
  localparam logic [5:0] EXT_CTRL_UTYPE       = 6'b000010;
  localparam logic [5:0] EXT_CTRL_JTYPE       = 6'b000001;

  localparam logic [31:0] EXT_NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [5:0]  fmt;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
  } enc_req_t;

  // True when v is representable as a k-bit two's complement value.
  function automatic logic fits_signed(input logic signed [31:0] v, input int unsigned k);
    logic signed [31:0] t;
    t = v >>> (k - 1);
    return (t == 32'sd0) || (t == -32'sd1);
  endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational field scatter: places the immediate into its format-specific
// bit positions and flags immediates the format cannot represent.
module imm_encoder_pack
  import imm_encoder_pkg::*;
(
  input  logic [5:0]  fmt,
  input  logic [31:0] imm,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output logic [31:0] inst,
  output logic        err
);

  logic        ok;
  logic [31:0] raw;

  always_comb begin
    ok  = 1'b0;
    raw = EXT_NOP_INST;
    case (fmt)
      EXT_CTRL_ITYPE: begin
        ok  = fits_signed($signed(imm), 12);
        raw = {imm[11:0], rs1, funct3, rd, opcode};
      end
      EXT_CTRL_ITYPE_SHAMT: begin
        ok  = (imm[31:5] == 27'd0);
        raw = {funct7, imm[4:0], rs1, funct3, rd, opcode};
      end
      EXT_CTRL_STYPE: begin
        ok  = fits_signed($signed(imm), 12);
        raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      end
      EXT_CTRL_BTYPE: begin
        ok  = fits_signed($signed(imm), 13) & ~imm[0];
        raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      end
      EXT_CTRL_UTYPE: begin
        ok  = (imm[11:0] == 12'd0);
        raw = {imm[31:12], rd, opcode};
      end
      EXT_CTRL_JTYPE: begin
        ok  = fits_signed($signed(imm), 21) & ~imm[0];
        raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      end
      default: begin
        ok  = 1'b0;
        raw = EXT_NOP_INST;
      end
    endcase
  end

  assign err  = ~ok;
  assign inst = ok ? raw : EXT_NOP_INST;

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready RV32I instruction assembler with a saturating count of
// errored results delivered downstream.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_fmt,
  input  logic [31:0]      in_imm,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  enc_req_t         req_p0;
  enc_req_t         req_p1;
  logic             vld_p1, vld_p1_d;
  logic [31:0]      inst_p1;
  logic             err_p1;
  logic [31:0]      inst_p2;
  logic             err_p2;
  logic             vld_p2, vld_p2_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             adv_p1, adv_p2, ld_p1, xfer_out;

  assign req_p0 = '{fmt: in_fmt, imm: in_imm, opcode: in_opcode, rd: in_rd,
                    rs1: in_rs1, rs2: in_rs2, funct3: in_funct3, funct7: in_funct7};

  // Ready terms depend only on registered state and out_ready, never on in_valid.
  assign adv_p2   = ~vld_p2 | out_ready;
  assign adv_p1   = ~vld_p1 | adv_p2;
  assign in_ready = adv_p1;
  assign ld_p1    = adv_p1 & in_valid;
  assign xfer_out = vld_p2 & out_ready;

  always_comb begin
    vld_p1_d  = vld_p1;
    vld_p2_d  = vld_p2;
    err_cnt_d = err_cnt_q;
    if (adv_p1) vld_p1_d = in_valid;
    if (adv_p2) vld_p2_d = vld_p1;
    if (xfer_out && err_p2) err_cnt_d = sat_inc(err_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      vld_p1    <= vld_p1_d;
      vld_p2    <= vld_p2_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // ---- stage p0 -> p1: capture request fields ----
  always_ff @(posedge clk) begin
    if (ld_p1) req_p1 <= req_p0;
  end

  imm_encoder_pack u_pack (
    .fmt    (req_p1.fmt),
    .imm    (req_p1.imm),
    .opcode (req_p1.opcode),
    .rd     (req_p1.rd),
    .rs1    (req_p1.rs1),
    .rs2    (req_p1.rs2),
    .funct3 (req_p1.funct3),
    .funct7 (req_p1.funct7),
    .inst   (inst_p1),
    .err    (err_p1)
  );

  // ---- stage p1 -> p2: output register ----
  always_ff @(posedge clk) begin
    if (adv_p2) begin
      inst_p2 <= inst_p1;
      err_p2  <= err_p1;
    end
  end

  // Data registers carry no reset; gating by the valid bit gives zero outputs when idle.
  assign out_valid = vld_p2;
  assign out_inst  = vld_p2 ? inst_p2 : 32'd0;
  assign out_err   = vld_p2 & err_p2;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized scoreboard bench for imm_encoder against an arithmetic reference model.
module tb_imm_encoder;
  import imm_encoder_pkg::*;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_fmt;
  logic [31:0]      in_imm;
  logic [6:0]       in_opcode;
  logic [4:0]       in_rd, in_rs1, in_rs2;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic             out_err;
  logic [CNT_W-1:0] err_cnt;

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_imm(in_imm), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   exp_cnt = 0;
  int   n_out = 0;
  int   force_stall = 0;
  bit   rand_ready = 0;
  bit   saw_full = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: range rules as plain integer arithmetic, then field placement.
  function automatic logic [32:0] ref_pack(input logic [5:0] fmt, input logic [31:0] imm,
                                           input logic [6:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [2:0] f3, input logic [6:0] f7);
    int          s;
    bit          ok;
    logic [31:0] w;
    s  = $signed(imm);
    ok = 0;
    w  = 32'h0;
    if (fmt == EXT_CTRL_ITYPE) begin
      ok = (s >= -2048) && (s <= 2047);
      w  = {imm[11:0], rs1, f3, rd, op};
    end else if (fmt == EXT_CTRL_ITYPE_SHAMT) begin
      ok = (s >= 0) && (s <= 31);
      w  = {f7, imm[4:0], rs1, f3, rd, op};
    end else if (fmt == EXT_CTRL_STYPE) begin
      ok = (s >= -2048) && (s <= 2047);
      w  = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    end else if (fmt == EXT_CTRL_BTYPE) begin
      ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
      w  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
    end else if (fmt == EXT_CTRL_UTYPE) begin
      ok = (imm % 4096) == 0;
      w  = {imm[31:12], rd, op};
    end else if (fmt == EXT_CTRL_JTYPE) begin
      ok = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
      w  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
    end
    return ok ? {1'b0, w} : {1'b1, 32'h00000013};
  endfunction

  task automatic send(input logic [5:0] fmt, input logic [31:0] imm, input logic [6:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3, input logic [6:0] f7,
                      input bit use_c, input logic [31:0] c_inst, input bit c_err);
    exp_t        e;
    logic [32:0] m;
    int          waited;
    m      = ref_pack(fmt, imm, op, rd, rs1, rs2, f3, f7);
    e.inst = use_c ? c_inst : m[31:0];
    e.err  = use_c ? c_err : m[32];
    @(negedge clk);
    in_fmt = fmt; in_imm = imm; in_opcode = op; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_valid = 1'b1;
    waited = 0;
    forever begin
      #2;
      if (in_ready) begin
        e.acc = cyc;
        q.push_back(e);
        return;
      end
      waited++;
      if (waited > 200) begin
        total++; bad++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", waited);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_rand();
    logic [5:0]  fmt;
    logic [31:0] imm;
    int          r;
    int          bnd[15] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                             1048574, 1048576, -1048576, -1048578, 31, 32, -1};
    r = $urandom_range(0, 7);
    case (r)
      0: fmt = EXT_CTRL_ITYPE;
      1: fmt = EXT_CTRL_ITYPE_SHAMT;
      2: fmt = EXT_CTRL_STYPE;
      3: fmt = EXT_CTRL_BTYPE;
      4: fmt = EXT_CTRL_UTYPE;
      5: fmt = EXT_CTRL_JTYPE;
      default: fmt = 6'($urandom);
    endcase
    r = $urandom_range(0, 3);
    case (r)
      0: imm = $urandom;
      1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: imm = 32'(bnd[$urandom_range(0, 14)]);
      default: imm = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 1));
    endcase
    send(fmt, imm, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
         3'($urandom), 7'($urandom), 0, 32'h0, 0);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0) return;
      @(negedge clk);
    end
    total++; bad++;
    $display("FAIL drain_timeout: %0d results still outstanding", q.size());
  endtask

  always @(negedge clk) begin
    if (force_stall > 0) begin
      out_ready = 1'b0;
      force_stall--;
    end else if (rand_ready) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor: pipeline holds at most two requests; the oldest becomes visible two
  // cycles after its accept, so occupancy and age predict every handshake signal.
  always @(negedge clk) begin
    #1;
    cyc++;
    if (!rst) begin
      check("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
      if (q.size() == 2 && !out_ready && !in_ready) saw_full = 1;
      check("out_valid", 32'(out_valid), 32'((q.size() > 0) && (cyc - q[0].acc >= 2)));
      check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
      if (out_valid && q.size() > 0) begin
        check("out_inst", out_inst, q[0].inst);
        check("out_err", 32'(out_err), 32'(q[0].err));
        if (out_ready) begin
          if (q[0].err && exp_cnt < CNT_MAX) exp_cnt++;
          void'(q.pop_front());
          n_out++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_fmt = '0; in_imm = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0;
    in_rs2 = '0; in_funct3 = '0; in_funct7 = '0;
    repeat (3) @(negedge clk);
    #3 rst = 1'b0;
    @(negedge clk); #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed encodings with hand-derived words
    send(EXT_CTRL_ITYPE, 32'hFFFFFFFF, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1, 32'hFFF00093, 0);
    idle(); drain();
    send(EXT_CTRL_BTYPE, 32'd8, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1, 32'h00000463, 0);
    send(EXT_CTRL_BTYPE, 32'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1, 32'h00000013, 1);
    idle(); drain(); #3;
    check("err_cnt_after_b3", 32'(err_cnt), 32'd1);
    send(EXT_CTRL_BTYPE, 32'd4096, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1, 32'h00000013, 1);
    send(EXT_CTRL_JTYPE, 32'd2048, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1, 32'h001000EF, 0);
    send(EXT_CTRL_UTYPE, 32'h12345000, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 1, 32'h123452B7, 0);
    send(EXT_CTRL_UTYPE, 32'h12345001, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 1, 32'h00000013, 1);
    send(6'b000000, 32'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1, 32'h00000013, 1);
    idle(); drain();

    // Back-to-back stream with a mid-stream three-cycle stall
    n0 = n_out; saw_full = 0;
    fork
      begin
        repeat (4) send_rand();
        idle();
      end
      begin
        repeat (2) @(negedge clk);
        #3 force_stall = 3;
      end
    join
    drain();
    check("stall_count", 32'(n_out - n0), 32'd4);
    check("stall_full_seen", 32'(saw_full), 32'd1);

    // Random stream with random backpressure
    rand_ready = 1;
    repeat (300) send_rand();
    idle(); drain();
    rand_ready = 0;

    // Reset with both stages occupied
    @(negedge clk); #3 force_stall = 20;
    send_rand(); send_rand(); idle();
    @(negedge clk); #3;
    rst = 1'b1; q.delete(); exp_cnt = 0;
    @(negedge clk); #3;
    rst = 1'b0; force_stall = 0;
    @(negedge clk); #3;
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_err_cnt", 32'(err_cnt), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (5) @(negedge clk);

    // Saturation of the error counter
    repeat (5) send(EXT_CTRL_UTYPE, 32'h00000001, 7'b0110111, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0,
                    1, 32'h00000013, 1);
    idle(); drain(); #3;
    check("err_cnt_saturated", 32'(err_cnt), 32'(CNT_MAX));

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
